red_pitaya_na_sweep_block: RTL and testbench
============================================

RED_PITAYA_NA_SWEEP_BLOCK -- requirements
Module: red_pitaya_na_sweep_block

Interface
REQ-001 Parameter LPFBITS, default 24: signed width of quadrature inputs.
REQ-002 Parameter PHASEBITS, default 32: width of the phase increment driven to the IQ oscillator.
REQ-003 Parameter SUMBITS, default 62: signed accumulator width per quadrature.
REQ-004 Parameter FIFOLOG2, default 4: log2 of the result FIFO depth.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low, ports clk_i and rstn_i.
REQ-006 clk_i  in  1  system clock.
REQ-007 rstn_i  in  1  async active-low reset.
REQ-008 quad1_i / quad2_i  in  LPFBITS each  signed low-passed I/Q from the IQ demodulator.
REQ-009 phase_inc_o  out  PHASEBITS  frequency word to the IQ oscillator.
REQ-010 freq_update_o  out  1  one-cycle pulse when phase_inc_o changes.
REQ-011 busy_o  out  1  high in every state except IDLE.
REQ-012 addr in 16, wen in 1, ren in 1, wdata in 32, ack out 1 (reg), rdata out 32 (reg): system-bus slave.

Function
REQ-013 Registers: 0x00 ctrl (W bit0 start strobe, bit1 abort strobe); 0x04 start_inc; 0x08 step_inc; 0x0C points[15:0]; 0x10 sleepcycles; 0x14 averages; 0x18 status RO {overflow, fifo_count, state}; 0x20/0x24 I sum lo[31:0]/hi[SUMBITS-1:32]; 0x28/0x2C Q sum lo/hi; unmapped reads return 0.
REQ-014 ack SHALL assert exactly one cycle after any wen|ren, with rdata valid in that cycle.
REQ-015 FSM states: IDLE, SETF, SLEEP, AVG, PUSH, WAITFIFO.
REQ-016 IDLE -> SETF on start strobe; index k cleared; start while busy ignored.
REQ-017 SETF (1 cycle): phase_inc_o <= start_inc + k*step_inc mod 2^PHASEBITS (wrap permitted), freq_update_o high that cycle, sums cleared, sleep counter loaded -> SLEEP.
REQ-018 SLEEP: decrement each cycle; at 0 -> AVG with average counter loaded; sleepcycles=0 goes to AVG next cycle.
REQ-019 AVG: each cycle add sign-extended quad1_i/quad2_i to I/Q sums, decrement counter; at 0 -> PUSH; averages=0 pushes zero sums.
REQ-020 PUSH: write {I,Q} to FIFO; k++; k==points -> IDLE, else -> SETF.
REQ-021 FIFO full at PUSH -> WAITFIFO; hold sums and phase_inc_o until not full, then push; no sample lost, overflow flag set sticky until next start.
REQ-022 points=0 -> IDLE after SETF-free one cycle, no push, no freq_update_o.
REQ-023 Read of 0x2C pops FIFO head; 0x20-0x2C show head; pop on empty returns 0 and leaves count unchanged.
REQ-024 Simultaneous push and pop on full FIFO SHALL both succeed, count unchanged.
REQ-025 Abort strobe forces IDLE next cycle from any state; FIFO contents and phase_inc_o retained.
REQ-026 Sums never overflow for averages <= 2^32 (LPFBITS+32 < SUMBITS).

Reset
REQ-027 On rstn_i low: state IDLE, all config registers 0, phase_inc_o 0, freq_update_o 0, busy_o 0, ack 0, rdata 0, FIFO empty, overflow 0.
REQ-028 Reset mid-sweep SHALL abandon the sweep with no further push.

Configuration
REQ-029 Macro RED_PITAYA_NA_FIFO_EN defined: FIFO depth 2^FIFOLOG2.
REQ-030 Macro undefined: single result register (depth 1), fifo_count field 0/1, all other behaviour identical.

Structure
REQ-031 Package red_pitaya_na_pkg holds FSM state encoding, register offset constants and default widths.
REQ-032 Sub-module red_pitaya_na_result_fifo: synchronous FIFO, width 2*SUMBITS, push/pop/full/empty/count.

Verification
REQ-033 start_inc=1000, step_inc=100, points=3, sleep=2, avg=4, quad1=5, quad2=-3 -> phase_inc_o 1000,1100,1200; three entries I=20, Q=-12.
REQ-034 start_inc=0xFFFFFF00, step=0x200, points=2 -> second phase_inc_o = 0x00000100.
REQ-035 points=20, avg=1, no reads -> stall in WAITFIFO at 16 entries, overflow=1; pop one -> sweep resumes, 20 results total.
REQ-036 Abort during AVG of point 2 -> busy_o low next cycle, FIFO holds 1 entry.
REQ-037 rstn_i low during SLEEP -> all outputs at reset values; pop on empty returns 0.
REQ-038 averages=0, sleep=0, points=1 -> one entry I=0, Q=0.

Source files
------------

// File: rtl/red_pitaya_na_pkg.sv
`default_nettype none
// ============================================================================
// Module   : red_pitaya_na_pkg
// Brief    : Shared state encoding, register map and default widths for the
//            network-analyser sweep block.
// Revision : 1.0
// ============================================================================
package red_pitaya_na_pkg;

    localparam int c_LPFBITS_DEF   = 24;
    localparam int c_PHASEBITS_DEF = 32;
    localparam int c_SUMBITS_DEF   = 62;
    localparam int c_FIFOLOG2_DEF  = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETF     = 3'd1,
        S_SLEEP    = 3'd2,
        S_AVG      = 3'd3,
        S_PUSH     = 3'd4,
        S_WAITFIFO = 3'd5
    } na_state_t;

    localparam logic [15:0] c_ADDR_CTRL   = 16'h0000;
    localparam logic [15:0] c_ADDR_START  = 16'h0004;
    localparam logic [15:0] c_ADDR_STEP   = 16'h0008;
    localparam logic [15:0] c_ADDR_POINTS = 16'h000C;
    localparam logic [15:0] c_ADDR_SLEEP  = 16'h0010;
    localparam logic [15:0] c_ADDR_AVG    = 16'h0014;
    localparam logic [15:0] c_ADDR_STATUS = 16'h0018;
    localparam logic [15:0] c_ADDR_ILO    = 16'h0020;
    localparam logic [15:0] c_ADDR_IHI    = 16'h0024;
    localparam logic [15:0] c_ADDR_QLO    = 16'h0028;
    localparam logic [15:0] c_ADDR_QHI    = 16'h002C;

endpackage
`default_nettype wire

// File: rtl/red_pitaya_na_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : red_pitaya_na_result_fifo
// Brief    : Synchronous result FIFO, depth 2^ADDRBITS; head reads 0 when empty.
// Revision : 1.0
// ============================================================================
module red_pitaya_na_result_fifo #(
    parameter int WIDTH    = 124,
    parameter int ADDRBITS = 4
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                push,
    input  logic [WIDTH-1:0]    wdata,
    input  logic                pop,
    output logic [WIDTH-1:0]    rdata,
    output logic                full,
    output logic                empty,
    output logic [ADDRBITS:0]   count
);

    localparam int c_DEPTH = 1 << ADDRBITS;

    logic [ADDRBITS:0] r_count;
    logic              w_do_push;
    logic              w_do_pop;
    logic [WIDTH-1:0]  w_head;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (ADDRBITS+1)'(c_DEPTH));
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = push && (!full || w_do_pop);
    assign count     = r_count;
    assign rdata     = empty ? '0 : w_head;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_count <= '0;
        end else if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - 1'b1;
        end
    end

    generate
        if (ADDRBITS == 0) begin : g_single
            logic [WIDTH-1:0] r_data;
            always_ff @(posedge clk_i) begin
                if (w_do_push) r_data <= wdata;
            end
            assign w_head = r_data;
        end else begin : g_ram
            logic [WIDTH-1:0]    r_mem [c_DEPTH];
            logic [ADDRBITS-1:0] r_wr_ptr;
            logic [ADDRBITS-1:0] r_rd_ptr;
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
            always_ff @(posedge clk_i) begin
                if (w_do_push) r_mem[r_wr_ptr] <= wdata;
            end
            assign w_head = r_mem[r_rd_ptr];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/red_pitaya_na_sweep_block.sv
`default_nettype none
// ============================================================================
// Module   : red_pitaya_na_sweep_block
// Brief    : Network-analyser frequency sweep with I/Q averaging and result
//            FIFO. Define RED_PITAYA_NA_FIFO_EN for a 2^FIFOLOG2-deep FIFO,
//            otherwise a single result register is used.
// Revision : 1.0
// ============================================================================
module red_pitaya_na_sweep_block
    import red_pitaya_na_pkg::*;
#(
    parameter int LPFBITS   = c_LPFBITS_DEF,
    parameter int PHASEBITS = c_PHASEBITS_DEF,
    parameter int SUMBITS   = c_SUMBITS_DEF,
    parameter int FIFOLOG2  = c_FIFOLOG2_DEF
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic signed [LPFBITS-1:0]  quad1_i,
    input  logic signed [LPFBITS-1:0]  quad2_i,
    output logic [PHASEBITS-1:0]       phase_inc_o,
    output logic                       freq_update_o,
    output logic                       busy_o,
    input  logic [15:0]                addr,
    input  logic                       wen,
    input  logic                       ren,
    input  logic [31:0]                wdata,
    output logic                       ack,
    output logic [31:0]                rdata
);

`ifdef RED_PITAYA_NA_FIFO_EN
    localparam int c_DEPTH_LOG2 = FIFOLOG2;
`else
    localparam int c_DEPTH_LOG2 = 0;
`endif

    na_state_t r_state, w_state_next;
    logic [31:0]               r_start_inc, r_step_inc, r_sleepcycles, r_averages;
    logic [15:0]               r_points, r_k;
    logic [31:0]               r_sleep_cnt, r_avg_cnt;
    logic [PHASEBITS-1:0]      r_next_inc, r_phase_inc;
    logic signed [SUMBITS-1:0] r_sum_i, r_sum_q;
    logic                      r_overflow, r_freq_update, r_ack;
    logic [31:0]               r_rdata, w_rdata;
    logic                      w_ctrl_wr, w_start, w_abort, w_pop, w_start_sweep;
    logic                      w_push, w_set_freq, w_full, w_empty;
    logic [2*SUMBITS-1:0]      w_head;
    logic [SUMBITS-1:0]        w_head_i, w_head_q;
    logic [c_DEPTH_LOG2:0]     w_count;
    logic [2:0]                w_state_bits;

    assign w_ctrl_wr     = wen && (addr == c_ADDR_CTRL);
    assign w_start       = w_ctrl_wr && wdata[0];
    assign w_abort       = w_ctrl_wr && wdata[1];
    assign w_pop         = ren && (addr == c_ADDR_QHI);
    assign w_start_sweep = (r_state == S_IDLE) && w_start && !w_abort;
    assign w_head_i      = w_head[2*SUMBITS-1:SUMBITS];
    assign w_head_q      = w_head[SUMBITS-1:0];
    assign w_state_bits  = r_state;

    assign phase_inc_o   = r_phase_inc;
    assign freq_update_o = r_freq_update;
    assign busy_o        = (r_state != S_IDLE);
    assign ack           = r_ack;
    assign rdata         = r_rdata;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_set_freq   = 1'b0;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_SETF;
            // k >= points only when points is 0 (or shrank mid-sweep): leave quietly.
            S_SETF: begin
                if (r_k >= r_points) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_set_freq   = 1'b1;
                    w_state_next = S_SLEEP;
                end
            end
            S_SLEEP: if (r_sleep_cnt == 32'd0) w_state_next = S_AVG;
            S_AVG:   if (r_avg_cnt == 32'd0) w_state_next = S_PUSH;
            S_PUSH, S_WAITFIFO: begin
                if (!w_full || w_pop) begin
                    w_push       = 1'b1;
                    w_state_next = (({1'b0, r_k} + 17'd1) >= {1'b0, r_points}) ? S_IDLE : S_SETF;
                end else begin
                    w_state_next = S_WAITFIFO;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = S_IDLE;
            w_push       = 1'b0;
            w_set_freq   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_k           <= '0;
            r_next_inc    <= '0;
            r_phase_inc   <= '0;
            r_freq_update <= 1'b0;
            r_sum_i       <= '0;
            r_sum_q       <= '0;
            r_sleep_cnt   <= '0;
            r_avg_cnt     <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_freq_update <= w_set_freq;
            if (w_start_sweep) begin
                r_k        <= '0;
                r_next_inc <= PHASEBITS'(r_start_inc);
                r_overflow <= 1'b0;
            end
            if (w_set_freq) begin
                r_phase_inc <= r_next_inc;
                r_sum_i     <= '0;
                r_sum_q     <= '0;
                r_sleep_cnt <= r_sleepcycles;
            end
            if (r_state == S_SLEEP) begin
                if (r_sleep_cnt == 32'd0) r_avg_cnt   <= r_averages;
                else                      r_sleep_cnt <= r_sleep_cnt - 32'd1;
            end
            if ((r_state == S_AVG) && (r_avg_cnt != 32'd0)) begin
                r_sum_i   <= r_sum_i + SUMBITS'(quad1_i);
                r_sum_q   <= r_sum_q + SUMBITS'(quad2_i);
                r_avg_cnt <= r_avg_cnt - 32'd1;
            end
            // Running phase word avoids a k*step multiplier; same result mod 2^PHASEBITS.
            if (w_push) begin
                r_k        <= r_k + 16'd1;
                r_next_inc <= r_next_inc + PHASEBITS'(r_step_inc);
            end
            if ((r_state == S_PUSH) && (w_state_next == S_WAITFIFO)) r_overflow <= 1'b1;
        end
    end

    red_pitaya_na_result_fifo #(
        .WIDTH    (2*SUMBITS),
        .ADDRBITS (c_DEPTH_LOG2)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (w_push),
        .wdata  ({r_sum_i, r_sum_q}),
        .pop    (w_pop),
        .rdata  (w_head),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );

    always_comb begin
        w_rdata = '0;
        case (addr)
            c_ADDR_START:  w_rdata = r_start_inc;
            c_ADDR_STEP:   w_rdata = r_step_inc;
            c_ADDR_POINTS: w_rdata = {16'd0, r_points};
            c_ADDR_SLEEP:  w_rdata = r_sleepcycles;
            c_ADDR_AVG:    w_rdata = r_averages;
            c_ADDR_STATUS: w_rdata = 32'({r_overflow, (FIFOLOG2+1)'(w_count), w_state_bits});
            c_ADDR_ILO:    w_rdata = w_head_i[31:0];
            c_ADDR_IHI:    w_rdata = 32'(signed'(w_head_i[SUMBITS-1:32]));
            c_ADDR_QLO:    w_rdata = w_head_q[31:0];
            c_ADDR_QHI:    w_rdata = 32'(signed'(w_head_q[SUMBITS-1:32]));
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_start_inc   <= '0;
            r_step_inc    <= '0;
            r_points      <= '0;
            r_sleepcycles <= '0;
            r_averages    <= '0;
            r_ack         <= 1'b0;
            r_rdata       <= '0;
        end else begin
            r_ack   <= wen || ren;
            r_rdata <= ren ? w_rdata : 32'd0;
            if (wen) begin
                case (addr)
                    c_ADDR_START:  r_start_inc   <= wdata;
                    c_ADDR_STEP:   r_step_inc    <= wdata;
                    c_ADDR_POINTS: r_points      <= wdata[15:0];
                    c_ADDR_SLEEP:  r_sleepcycles <= wdata;
                    c_ADDR_AVG:    r_averages    <= wdata;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_na_sweep_block.sv
`timescale 1ns/1ps
module tb_red_pitaya_na_sweep_block;

    localparam int LPFBITS   = 24;
    localparam int PHASEBITS = 32;
    localparam int SUMBITS   = 62;
    localparam int FIFOLOG2  = 4;
`ifdef RED_PITAYA_NA_FIFO_EN
    localparam int DEPTH = 1 << FIFOLOG2;
`else
    localparam int DEPTH = 1;
`endif

    logic                      clk_i   = 1'b0;
    logic                      rstn_i  = 1'b0;
    logic signed [LPFBITS-1:0] quad1_i = '0;
    logic signed [LPFBITS-1:0] quad2_i = '0;
    logic [PHASEBITS-1:0]      phase_inc_o;
    logic                      freq_update_o;
    logic                      busy_o;
    logic [15:0]               addr  = '0;
    logic                      wen   = 1'b0;
    logic                      ren   = 1'b0;
    logic [31:0]               wdata = '0;
    logic                      ack;
    logic [31:0]               rdata;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] q_phase[$];
    longint      got_i[$];
    longint      got_q[$];

    red_pitaya_na_sweep_block #(
        .LPFBITS(LPFBITS), .PHASEBITS(PHASEBITS), .SUMBITS(SUMBITS), .FIFOLOG2(FIFOLOG2)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .quad1_i(quad1_i), .quad2_i(quad2_i),
        .phase_inc_o(phase_inc_o), .freq_update_o(freq_update_o), .busy_o(busy_o),
        .addr(addr), .wen(wen), .ren(ren), .wdata(wdata), .ack(ack), .rdata(rdata)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (rstn_i && freq_update_o) q_phase.push_back(phase_inc_o);

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk_i); addr = a; wdata = d; wen = 1'b1;
        @(negedge clk_i); wen = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic k);
        @(negedge clk_i); addr = a; ren = 1'b1;
        @(negedge clk_i); ren = 1'b0; d = rdata; k = ack;
    endtask

    task automatic read_entry(output longint vi, output longint vq);
        logic [31:0] lo, hi; logic k;
        bus_read(16'h20, lo, k); bus_read(16'h24, hi, k); vi = longint'({hi, lo});
        bus_read(16'h28, lo, k); bus_read(16'h2C, hi, k); vq = longint'({hi, lo});
    endtask

    task automatic start_sweep(input logic [31:0] st, input logic [31:0] sp, input int pts,
                               input int sl, input int av);
        bus_write(16'h04, st); bus_write(16'h08, sp); bus_write(16'h0C, 32'(pts));
        bus_write(16'h10, 32'(sl)); bus_write(16'h14, 32'(av));
        q_phase.delete();
        bus_write(16'h00, 32'd1);
    endtask

    // Collects n results by polling status and popping whatever is available.
    task automatic drain(input int n, input int budget, output bit timed_out);
        logic [31:0] st; logic k; longint vi, vq; int iter;
        timed_out = 1'b0; iter = 0;
        got_i.delete(); got_q.delete();
        while (got_i.size() < n) begin
            bus_read(16'h18, st, k);
            if (st[3 +: FIFOLOG2+1] != 0) begin
                read_entry(vi, vq); got_i.push_back(vi); got_q.push_back(vq);
            end
            iter++;
            if (iter > budget) begin timed_out = 1'b1; break; end
        end
        iter = 0;
        while (busy_o && iter < budget) begin @(negedge clk_i); iter++; end
        if (busy_o) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        n_cmp++; if (phase_inc_o !== '0) begin n_fail++; $display("FAIL reset_phase got=%h exp=0", phase_inc_o); end
        n_cmp++; if (freq_update_o !== 1'b0) begin n_fail++; $display("FAIL reset_freq got=%b exp=0", freq_update_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_cmp++; if (ack !== 1'b0 || rdata !== 32'd0) begin n_fail++; $display("FAIL reset_bus ack=%b rdata=%h exp=0/0", ack, rdata); end
        rstn_i = 1'b1;
    endtask

    task automatic test_bus_regs();
        logic [31:0] d, v[5]; logic k;
        for (int i = 0; i < 6; i++) begin
            bus_read(16'(4 + 4*i), d, k);
            n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL reg_reset_%0d got=%h exp=0", i, d); end
        end
        for (int i = 0; i < 5; i++) begin v[i] = $urandom(); bus_write(16'(4 + 4*i), v[i]); end
        v[2] = {16'd0, v[2][15:0]};
        for (int i = 0; i < 5; i++) begin
            bus_read(16'(4 + 4*i), d, k);
            n_cmp++; if (d !== v[i] || k !== 1'b1) begin n_fail++; $display("FAIL reg_rw_%0d got=%h ack=%b exp=%h ack=1", i, d, k, v[i]); end
        end
        bus_read(16'h1C, d, k);
        n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped got=%h exp=0", d); end
        @(negedge clk_i);
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ack_pulse got=%b exp=0", ack); end
    endtask

    task automatic check_sweep(input string nm, input logic [31:0] st, input logic [31:0] sp,
                               input int pts, input int av, input int q1, input int q2);
        bit to;
        quad1_i = q1[LPFBITS-1:0]; quad2_i = q2[LPFBITS-1:0];
        start_sweep(st, sp, pts, $urandom_range(0, 5), av);
        drain(pts, 400, to);
        n_cmp++; if (to || got_i.size() != pts || q_phase.size() != pts) begin
            n_fail++; $display("FAIL %s_count got=%0d/%0d exp=%0d timeout=%0d", nm, got_i.size(), q_phase.size(), pts, to);
        end
        for (int k = 0; k < got_i.size() && k < q_phase.size(); k++) begin
            logic [31:0] ep; ep = st + 32'(k) * sp;
            n_cmp++; if (q_phase[k] !== ep) begin n_fail++; $display("FAIL %s_phase%0d got=%h exp=%h", nm, k, q_phase[k], ep); end
            n_cmp++; if (got_i[k] != longint'(av) * q1 || got_q[k] != longint'(av) * q2) begin
                n_fail++; $display("FAIL %s_sum%0d got=%0d,%0d exp=%0d,%0d", nm, k, got_i[k], got_q[k], longint'(av) * q1, longint'(av) * q2);
            end
        end
    endtask

    task automatic test_directed();
        check_sweep("directed", 32'd1000, 32'd100, 3, 4, 5, -3);
        check_sweep("wrap", 32'hFFFFFF00, 32'h200, 2, 1, 7, 9);
        n_cmp++; if (q_phase.size() != 2 || q_phase[1] !== 32'h100) begin n_fail++; $display("FAIL wrap_second got=%h exp=00000100", q_phase[1]); end
    endtask

    task automatic test_random();
        int q1, q2;
        for (int it = 0; it < 4; it++) begin
            q1 = int'($urandom_range(0, 32'h00FFFFFF)) - 32'sh00800000;
            q2 = int'($urandom_range(0, 32'h00FFFFFF)) - 32'sh00800000;
            check_sweep("random", $urandom(), $urandom(), $urandom_range(1, 4), $urandom_range(0, 6), q1, q2);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] st; logic k; longint vi, vq; bit to; int iter;
        quad1_i = 24'sd11; quad2_i = -24'sd6;
        start_sweep(32'h10, 32'h10, 20, 0, 1);
        iter = 0;
        do begin bus_read(16'h18, st, k); iter++; end while (st[2:0] != 3'd5 && iter < 500);
        n_cmp++; if (st[2:0] != 3'd5 || st[3 +: FIFOLOG2+1] != DEPTH || st[4+FIFOLOG2] !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL ovf_stall state=%0d count=%0d ovf=%b exp=5/%0d/1", st[2:0], st[3 +: FIFOLOG2+1], st[4+FIFOLOG2], DEPTH);
        end
        read_entry(vi, vq);
        n_cmp++; if (vi != 11 || vq != -6) begin n_fail++; $display("FAIL ovf_head got=%0d,%0d exp=11,-6", vi, vq); end
        bus_read(16'h18, st, k);
        n_cmp++; if (st[3 +: FIFOLOG2+1] != DEPTH) begin n_fail++; $display("FAIL push_pop_full count=%0d exp=%0d", st[3 +: FIFOLOG2+1], DEPTH); end
        drain(19, 600, to);
        n_cmp++; if (to || got_i.size() != 19 || q_phase.size() != 20) begin
            n_fail++; $display("FAIL ovf_total got=%0d phases=%0d exp=19/20", got_i.size(), q_phase.size());
        end
        for (int j = 0; j < got_i.size(); j++) begin
            n_cmp++; if (got_i[j] != 11 || got_q[j] != -6) begin n_fail++; $display("FAIL ovf_sum%0d got=%0d,%0d exp=11,-6", j, got_i[j], got_q[j]); end
        end
        n_cmp++; if (q_phase.size() == 20 && q_phase[19] !== 32'h10 + 32'd19 * 32'h10) begin n_fail++; $display("FAIL ovf_phase got=%h exp=%h", q_phase[19], 32'h140); end
        bus_read(16'h18, st, k);
        n_cmp++; if (st[4+FIFOLOG2] !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", st[4+FIFOLOG2]); end
    endtask

    task automatic test_avg_zero();
        logic [31:0] st; logic k; bit to;
        quad1_i = 24'sd1234; quad2_i = -24'sd77;
        start_sweep(32'd7, 32'd1, 1, 0, 0);
        drain(1, 100, to);
        n_cmp++; if (to || got_i.size() != 1 || got_i[0] != 0 || got_q[0] != 0) begin
            n_fail++; $display("FAIL avg_zero got=%0d,%0d n=%0d exp=0,0 n=1", got_i[0], got_q[0], got_i.size());
        end
        bus_read(16'h18, st, k);
        n_cmp++; if (st[4+FIFOLOG2] !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared got=%b exp=0", st[4+FIFOLOG2]); end
    endtask

    task automatic test_points_zero();
        logic [31:0] st; logic k;
        start_sweep(32'd5, 32'd5, 0, 0, 0);
        repeat (6) @(negedge clk_i);
        bus_read(16'h18, st, k);
        n_cmp++; if (busy_o !== 1'b0 || q_phase.size() != 0 || st !== 32'd0) begin
            n_fail++; $display("FAIL points_zero busy=%b pulses=%0d status=%h exp=0/0/0", busy_o, q_phase.size(), st);
        end
    endtask

    task automatic test_abort();
        logic [31:0] st; logic k; longint vi, vq; int iter;
        quad1_i = -24'sd3; quad2_i = 24'sd8;
        start_sweep(32'd2000, 32'd300, 5, 2, 50);
        iter = 0;
        do begin bus_read(16'h18, st, k); iter++; end
        while (!(st[2:0] == 3'd3 && st[3 +: FIFOLOG2+1] == 1) && iter < 300);
        bus_write(16'h00, 32'd2);
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
        n_cmp++; if (phase_inc_o !== 32'd2300) begin n_fail++; $display("FAIL abort_phase got=%0d exp=2300", phase_inc_o); end
        bus_read(16'h18, st, k);
        n_cmp++; if (st[2:0] != 3'd0 || st[3 +: FIFOLOG2+1] != 1) begin n_fail++; $display("FAIL abort_fifo state=%0d count=%0d exp=0/1", st[2:0], st[3 +: FIFOLOG2+1]); end
        read_entry(vi, vq);
        n_cmp++; if (vi != -150 || vq != 400) begin n_fail++; $display("FAIL abort_entry got=%0d,%0d exp=-150,400", vi, vq); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] st, d; logic k;
        start_sweep(32'd99, 32'd1, 3, 1000, 2);
        repeat (3) @(negedge clk_i);
        bus_read(16'h18, st, k);
        n_cmp++; if (st[2:0] != 3'd2) begin n_fail++; $display("FAIL mid_sleep state=%0d exp=2", st[2:0]); end
        rstn_i = 1'b0; #1;
        n_cmp++; if (phase_inc_o !== '0 || busy_o !== 1'b0 || freq_update_o !== 1'b0 || ack !== 1'b0 || rdata !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset phase=%h busy=%b freq=%b ack=%b rdata=%h exp=all 0", phase_inc_o, busy_o, freq_update_o, ack, rdata);
        end
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        q_phase.delete();
        bus_read(16'h2C, d, k);
        n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL pop_empty got=%h exp=0", d); end
        bus_read(16'h18, st, k);
        n_cmp++; if (st !== 32'd0) begin n_fail++; $display("FAIL pop_empty_status got=%h exp=0", st); end
        repeat (30) @(negedge clk_i);
        n_cmp++; if (busy_o !== 1'b0 || q_phase.size() != 0) begin n_fail++; $display("FAIL mid_abandon busy=%b pulses=%0d exp=0/0", busy_o, q_phase.size()); end
    endtask

    initial begin
        test_reset();
        test_bus_regs();
        test_directed();
        test_random();
        test_overflow();
        test_avg_zero();
        test_points_zero();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
